// File: rtl/light_timer_pkg.sv
// Shared types and constants for the traffic-controller countdown timer bank.
package light_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } ch_state_t;

  localparam int DEF_RST_VAL  = 18;
  localparam int DEF_WARN_TH  = 3;
  localparam int DEF_TICK_DIV = 50000000;

  // Standard phase durations in seconds, loaded by the phase FSM.
  localparam int PHASE_GREEN  = 18;
  localparam int PHASE_YELLOW = 3;
  localparam int PHASE_RED    = 21;

endpackage

// File: rtl/light_timer_ch.sv
// One countdown channel: load/pause/one-shot/auto-reload with expiry pulse and warn flag.
module light_timer_ch
  import light_timer_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int RST_VAL = DEF_RST_VAL,
  parameter int WARN_TH = DEF_WARN_TH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] reload_val,
  output logic [CNT_W-1:0] count,
  output logic             finish,
  output logic             expire,
  output logic             warn,
  output ch_state_t        state
);

  localparam logic [CNT_W-1:0] RST_V  = CNT_W'(RST_VAL);
  localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_TH);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= RST_V;
      state  <= ST_IDLE;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (load) begin
        count <= load_val;
        state <= run ? ST_COUNT : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (run) state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (!run) begin
              state <= ST_IDLE;
            end else if (tick) begin
              // Zero is shown for a full tick before reload or expiry.
              if (count > ONE) begin
                count <= count - ONE;
              end else if (count == ONE) begin
                count  <= '0;
                expire <= 1'b1;
              end else if (auto_reload) begin
                count <= reload_val;
              end else begin
                state <= ST_EXPIRED;
              end
            end
          end
          ST_EXPIRED: begin
            state <= ST_EXPIRED;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign finish = (count == '0);
  assign warn   = (count != '0) && (count <= WARN_V);

endmodule

// File: rtl/light_timer_bank.sv
// Bank of N_CH independent countdown timers sharing one tick (internal prescaler or external strobe).
module light_timer_bank
  import light_timer_pkg::*;
#(
  parameter int CNT_W        = 5,
  parameter int N_CH         = 2,
  parameter int RST_VAL      = DEF_RST_VAL,
  parameter int WARN_TH      = DEF_WARN_TH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int USE_EXT_TICK = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_tick,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH*CNT_W-1:0] load_val,
  input  logic [N_CH-1:0]       run,
  input  logic [N_CH-1:0]       auto_reload,
  input  logic [N_CH*CNT_W-1:0] reload_val,
  output logic [N_CH*CNT_W-1:0] count,
  output logic [N_CH-1:0]       finish,
  output logic [N_CH-1:0]       expire,
  output logic [N_CH-1:0]       warn,
  output logic                  tick
);

  generate
    if (USE_EXT_TICK != 0) begin : g_ext
      assign tick = ext_tick;
    end else begin : g_pre
      localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
      localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

      logic [DIV_W-1:0] div_cnt;
      logic             ext_tick_unused;

      assign ext_tick_unused = ext_tick;

      // Tick is asserted on the last count, so the first one lands TICK_DIV cycles after reset.
      always_ff @(posedge clk) begin
        if (!rst_n)               div_cnt <= '0;
        else if (div_cnt == LAST) div_cnt <= '0;
        else                      div_cnt <= div_cnt + 1'b1;
      end

      assign tick = (div_cnt == LAST);
    end
  endgenerate

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t state_unused;  // per-channel state tap for debug and checkers

    light_timer_ch #(
      .CNT_W   (CNT_W),
      .RST_VAL (RST_VAL),
      .WARN_TH (WARN_TH)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .load        (load[i]),
      .load_val    (load_val[i*CNT_W +: CNT_W]),
      .run         (run[i]),
      .auto_reload (auto_reload[i]),
      .reload_val  (reload_val[i*CNT_W +: CNT_W]),
      .count       (count[i*CNT_W +: CNT_W]),
      .finish      (finish[i]),
      .expire      (expire[i]),
      .warn        (warn[i]),
      .state       (state_unused)
    );
  end

endmodule

// File: tb/tb_light_timer_bank.sv
// Directed bench for light_timer_bank with CNT_W=5, N_CH=2, TICK_DIV=4.
module tb_light_timer_bank;
  import light_timer_pkg::*;

  localparam int W = 5;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ext_tick = 1'b0;
  logic [N-1:0] load = '0;
  logic [N-1:0] run = '0;
  logic [N-1:0] auto_reload = '0;
  logic [N*W-1:0] load_val = '0;
  logic [N*W-1:0] reload_val = '0;
  logic [N*W-1:0] count;
  logic [N-1:0] finish;
  logic [N-1:0] expire;
  logic [N-1:0] warn;
  logic         tick;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, got no summary want summary");
    $fatal(1, "watchdog");
  end

  light_timer_bank #(
    .CNT_W(W), .N_CH(N), .RST_VAL(18), .WARN_TH(3), .TICK_DIV(4), .USE_EXT_TICK(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ext_tick(ext_tick), .load(load), .load_val(load_val),
    .run(run), .auto_reload(auto_reload), .reload_val(reload_val), .count(count),
    .finish(finish), .expire(expire), .warn(warn), .tick(tick)
  );

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] cnt(input int i);
    return count[i*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance past the next tick edge; timeout counts as a failed comparison.
  task automatic wait_tick(input string tag);
    int i;
    i = 0;
    while (tick !== 1'b1 && i < 8) begin step(); i++; end
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL %s_tick_timeout: got tick=%b want 1", tag, tick); end
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; run = 2'b11;
    repeat (3) step();
    n_cmp++; if (cnt(0) !== 5'd18) begin n_err++; $display("FAIL rst_cnt0: got %0d want 18", cnt(0)); end
    n_cmp++; if (cnt(1) !== 5'd18) begin n_err++; $display("FAIL rst_cnt1: got %0d want 18", cnt(1)); end
    n_cmp++; if (finish !== 2'b00) begin n_err++; $display("FAIL rst_finish: got %b want 00", finish); end
    n_cmp++; if (warn !== 2'b00) begin n_err++; $display("FAIL rst_warn: got %b want 00", warn); end
    n_cmp++; if (expire !== 2'b00) begin n_err++; $display("FAIL rst_expire: got %b want 00", expire); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", tick); end
    n_cmp++; if (dut.g_ch[0].u_ch.state !== ST_IDLE) begin n_err++; $display("FAIL rst_state0: got %0d want %0d", dut.g_ch[0].u_ch.state, ST_IDLE); end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        n_cmp++; if (tick !== (k == 3)) begin n_err++; $display("FAIL first_tick_k%0d: got %b want %b", k, tick, (k == 3)); end
        n_cmp++; if (cnt(0) !== 5'd18) begin n_err++; $display("FAIL hold18_k%0d: got %0d want 18", k, cnt(0)); end
      end else begin
        n_cmp++; if (cnt(0) !== 5'd17) begin n_err++; $display("FAIL first_dec0: got %0d want 17", cnt(0)); end
        n_cmp++; if (cnt(1) !== 5'd17) begin n_err++; $display("FAIL first_dec1: got %0d want 17", cnt(1)); end
      end
    end
  endtask

  task automatic test_autoreload();
    int fin_cycles, exp_pulses;
    auto_reload[0] = 1'b1; reload_val[W-1:0] = 5'd7;
    load = 2'b01; load_val[W-1:0] = 5'd3;
    step(); load = '0;
    n_cmp++; if (cnt(0) !== 5'd3 || warn[0] !== 1'b1) begin n_err++; $display("FAIL ar_load3: got cnt=%0d warn=%b want 3/1", cnt(0), warn[0]); end
    wait_tick("ar2");
    n_cmp++; if (cnt(0) !== 5'd2 || warn[0] !== 1'b1) begin n_err++; $display("FAIL ar_2: got cnt=%0d warn=%b want 2/1", cnt(0), warn[0]); end
    wait_tick("ar1");
    n_cmp++; if (cnt(0) !== 5'd1 || warn[0] !== 1'b1 || finish[0] !== 1'b0) begin n_err++; $display("FAIL ar_1: got cnt=%0d warn=%b fin=%b want 1/1/0", cnt(0), warn[0], finish[0]); end
    wait_tick("ar0");
    n_cmp++; if (cnt(0) !== 5'd0 || expire[0] !== 1'b1 || warn[0] !== 1'b0) begin n_err++; $display("FAIL ar_0: got cnt=%0d exp=%b warn=%b want 0/1/0", cnt(0), expire[0], warn[0]); end
    fin_cycles = int'(finish[0]); exp_pulses = int'(expire[0]);
    for (int i = 0; i < 10 && cnt(0) == 5'd0; i++) begin
      step();
      if (finish[0]) fin_cycles++;
      if (expire[0]) exp_pulses++;
    end
    n_cmp++; if (fin_cycles != 4) begin n_err++; $display("FAIL ar_finish_cycles: got %0d want 4", fin_cycles); end
    n_cmp++; if (exp_pulses != 1) begin n_err++; $display("FAIL ar_expire_pulses: got %0d want 1", exp_pulses); end
    n_cmp++; if (cnt(0) !== 5'd7 || warn[0] !== 1'b0) begin n_err++; $display("FAIL ar_reload: got cnt=%0d warn=%b want 7/0", cnt(0), warn[0]); end
    wait_tick("ar6");
    n_cmp++; if (cnt(0) !== 5'd6) begin n_err++; $display("FAIL ar_6: got %0d want 6", cnt(0)); end
  endtask

  task automatic test_oneshot();
    auto_reload[1] = 1'b0; run[1] = 1'b1;
    load = 2'b10; load_val[2*W-1:W] = 5'd2;
    step(); load = '0;
    n_cmp++; if (cnt(1) !== 5'd2) begin n_err++; $display("FAIL os_load2: got %0d want 2", cnt(1)); end
    wait_tick("os1");
    n_cmp++; if (cnt(1) !== 5'd1) begin n_err++; $display("FAIL os_1: got %0d want 1", cnt(1)); end
    wait_tick("os0");
    n_cmp++; if (cnt(1) !== 5'd0 || expire[1] !== 1'b1 || finish[1] !== 1'b1) begin n_err++; $display("FAIL os_0: got cnt=%0d exp=%b fin=%b want 0/1/1", cnt(1), expire[1], finish[1]); end
    wait_tick("os_exp");
    n_cmp++; if (dut.g_ch[1].u_ch.state !== ST_EXPIRED) begin n_err++; $display("FAIL os_state: got %0d want %0d", dut.g_ch[1].u_ch.state, ST_EXPIRED); end
    for (int i = 0; i < 5; i++) begin
      run[1] = ~run[1];
      wait_tick("os_hold");
      n_cmp++; if (cnt(1) !== 5'd0 || expire[1] !== 1'b0) begin n_err++; $display("FAIL os_hold%0d: got cnt=%0d exp=%b want 0/0", i, cnt(1), expire[1]); end
    end
    run[1] = 1'b1; load = 2'b10; load_val[2*W-1:W] = 5'd9;
    step(); load = '0;
    n_cmp++; if (cnt(1) !== 5'd9 || dut.g_ch[1].u_ch.state !== ST_COUNT) begin n_err++; $display("FAIL os_reload9: got cnt=%0d st=%0d want 9/%0d", cnt(1), dut.g_ch[1].u_ch.state, ST_COUNT); end
    wait_tick("os8");
    n_cmp++; if (cnt(1) !== 5'd8) begin n_err++; $display("FAIL os_8: got %0d want 8", cnt(1)); end
  endtask

  task automatic test_pause();
    load = 2'b01; load_val[W-1:0] = 5'd10;
    step(); load = '0; run[0] = 1'b0;
    n_cmp++; if (cnt(0) !== 5'd10 || cnt(1) !== 5'd8) begin n_err++; $display("FAIL pz_load: got %0d/%0d want 10/8", cnt(0), cnt(1)); end
    for (int i = 1; i <= 3; i++) begin
      wait_tick("pz");
      n_cmp++; if (cnt(0) !== 5'd10) begin n_err++; $display("FAIL pz_hold%0d: got %0d want 10", i, cnt(0)); end
      n_cmp++; if (cnt(1) !== 5'(8 - i)) begin n_err++; $display("FAIL pz_ch1_%0d: got %0d want %0d", i, cnt(1), 8 - i); end
    end
    run[0] = 1'b1;
    wait_tick("pz_resume");
    n_cmp++; if (cnt(0) !== 5'd9 || cnt(1) !== 5'd4) begin n_err++; $display("FAIL pz_resume: got %0d/%0d want 9/4", cnt(0), cnt(1)); end
  endtask

  task automatic test_collision();
    int i;
    i = 0;
    while (tick !== 1'b1 && i < 8) begin step(); i++; end
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL col_sync1: got tick=%b want 1", tick); end
    load = 2'b01; load_val[W-1:0] = 5'd12;
    step(); load = '0;
    n_cmp++; if (cnt(0) !== 5'd12) begin n_err++; $display("FAIL col_load12: got %0d want 12", cnt(0)); end
    n_cmp++; if (cnt(1) !== 5'd3) begin n_err++; $display("FAIL col_ch1: got %0d want 3", cnt(1)); end
    i = 0;
    while (tick !== 1'b1 && i < 8) begin step(); i++; end
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL col_sync2: got tick=%b want 1", tick); end
    load = 2'b01; load_val[W-1:0] = 5'd0;
    step(); load = '0;
    n_cmp++; if (cnt(0) !== 5'd0 || finish[0] !== 1'b1 || expire[0] !== 1'b0) begin n_err++; $display("FAIL col_load0: got cnt=%0d fin=%b exp=%b want 0/1/0", cnt(0), finish[0], expire[0]); end
    step();
    n_cmp++; if (expire[0] !== 1'b0) begin n_err++; $display("FAIL col_noexp: got %b want 0", expire[0]); end
  endtask

  task automatic test_reset_mid();
    load = 2'b11; load_val = {5'd15, 5'd20};
    step(); load = '0;
    n_cmp++; if (cnt(0) !== 5'd20 || cnt(1) !== 5'd15) begin n_err++; $display("FAIL rm_load: got %0d/%0d want 20/15", cnt(0), cnt(1)); end
    wait_tick("rm");
    n_cmp++; if (cnt(0) !== 5'd19 || cnt(1) !== 5'd14) begin n_err++; $display("FAIL rm_dec: got %0d/%0d want 19/14", cnt(0), cnt(1)); end
    rst_n = 1'b0; #3; rst_n = 1'b1;
    step();
    n_cmp++; if (cnt(0) !== 5'd19 || cnt(1) !== 5'd14 || tick !== 1'b0) begin n_err++; $display("FAIL rm_glitch: got %0d/%0d tick=%b want 19/14/0", cnt(0), cnt(1), tick); end
    load = 2'b10; load_val[2*W-1:W] = 5'd1;
    step(); load = '0;
    n_cmp++; if (cnt(1) !== 5'd1 || tick !== 1'b0) begin n_err++; $display("FAIL rm_load1: got cnt=%0d tick=%b want 1/0", cnt(1), tick); end
    step();
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL rm_prescale_kept: got tick=%b want 1", tick); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (cnt(0) !== 5'd18 || cnt(1) !== 5'd18) begin n_err++; $display("FAIL rm_cnt: got %0d/%0d want 18/18", cnt(0), cnt(1)); end
    n_cmp++; if (expire !== 2'b00 || tick !== 1'b0) begin n_err++; $display("FAIL rm_exp_tick: got exp=%b tick=%b want 00/0", expire, tick); end
    n_cmp++; if (dut.g_ch[0].u_ch.state !== ST_IDLE || dut.g_ch[1].u_ch.state !== ST_IDLE) begin n_err++; $display("FAIL rm_state: got %0d/%0d want %0d/%0d", dut.g_ch[0].u_ch.state, dut.g_ch[1].u_ch.state, ST_IDLE, ST_IDLE); end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        n_cmp++; if (tick !== (k == 3)) begin n_err++; $display("FAIL rm_tick_k%0d: got %b want %b", k, tick, (k == 3)); end
      end else begin
        n_cmp++; if (cnt(0) !== 5'd17 || cnt(1) !== 5'd17) begin n_err++; $display("FAIL rm_restart: got %0d/%0d want 17/17", cnt(0), cnt(1)); end
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_autoreload();
    test_oneshot();
    test_pause();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/light_timer_bank.md
Name: light_timer_bank

Overview:
Parametrised bank of N_CH independent countdown timers for the traffic controller. It drives per-direction and per-pedestrian phase durations from one shared 1-second tick.
Replaces the single fixed 5-bit countdown. Adds:
- configurable width and channel count
- a built-in tick prescaler (or an external tick)
- explicit load
- a one-shot or auto-reload mode
- pause
- an expiry pulse and a "warning" flag for the last seconds of a phase, used for amber/flash logic.
Sits between the phase FSM and the display/lamp drivers.

Parameters:
CNT_W, 5, width of each channel's count
N_CH, 2, number of independent channels
RST_VAL, 18, count value of every channel after reset
WARN_TH, 3, warn asserted while 0 < count <= WARN_TH
TICK_DIV, 50000000, clk cycles per internal tick (>=1)
USE_EXT_TICK, 0, 1 = use ext_tick and remove the prescaler

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ext_tick  in  1  external 1-cycle tick strobe, used only when USE_EXT_TICK=1
load  in  N_CH  per-channel load strobe
load_val  in  N_CH*CNT_W  per-channel load value; channel i at [i*CNT_W +: CNT_W]
run  in  N_CH  per-channel level enable; 0 = pause
auto_reload  in  N_CH  per-channel level; 1 = reload on expiry, 0 = one-shot
reload_val  in  N_CH*CNT_W  per-channel reload value
count  out  N_CH*CNT_W  current count per channel (registered)
finish  out  N_CH  count == 0 (combinational from register)
expire  out  N_CH  1-cycle pulse, registered
warn  out  N_CH  0 < count <= WARN_TH
tick  out  1  active tick strobe, observable

Behaviour:
- Reset is synchronous: only sampled at posedge clk when rst_n=0. Reset values:
  - count = RST_VAL on all channels
  - state = IDLE
  - expire = 0
  - prescaler counter = 0
  - finish and warn follow from count.
- Prescaler (USE_EXT_TICK=0):
  - counter runs 0..TICK_DIV-1 and wraps.
  - tick = (counter == TICK_DIV-1), so the first tick occurs on the TICK_DIV-th cycle after reset release.
  - TICK_DIV=1 gives tick=1 every cycle.
  - USE_EXT_TICK=1: tick = ext_tick.
- Per-channel states: IDLE, COUNT, EXPIRED. Priority per edge is reset > load > state logic.
- load=1, any state:
  - count <= load_val; next state is COUNT if run=1, else IDLE.
  - No decrement that cycle, even if tick=1. No expire pulse, even when load_val=0.
- IDLE:
  - Count held. run=1 moves to COUNT; no decrement on the transition edge.
- COUNT:
  - run=0: to IDLE, count held (pause).
  - tick & run & count>1: count-1.
  - tick & run & count==1: count <= 0 and expire <= 1 for exactly one cycle.
  - tick & run & count==0, auto_reload=1: count <= reload_val and stay in COUNT. A reload_val of 0 is legal: count stays 0 and no further expire pulses occur.
  - tick & run & count==0, auto_reload=0: to EXPIRED.
  - Zero is therefore displayed for one full tick before reload, which matches the existing phase timing.
- EXPIRED:
  - count held at 0; run, tick and auto_reload are ignored. Only load or reset exits.
- Arithmetic:
  - Unsigned, CNT_W bits. Decrement never goes below 0; there is no wrap to all-ones.
  - load_val and reload_val are used verbatim.
- Channels are fully independent; only tick is shared.
- expire is otherwise 0.

Decomposition:
- Package light_timer_pkg holds:
  - the channel state enum (IDLE/COUNT/EXPIRED)
  - default constants for RST_VAL, WARN_TH and TICK_DIV
  - the standard phase durations (GREEN=18, YELLOW=3, RED=21) used by the FSM.
- Sub-module light_timer_ch: one channel (state register, count, expire, finish, warn), instantiated N_CH times by generate.
- The prescaler stays inline in light_timer_bank.

Test Plan:
Bench config: CNT_W=5, N_CH=2, TICK_DIV=4.
1. Reset, then run=2'b11 -> both counts 18, finish=0, warn=0; the first tick comes 4 cycles after reset release, and both counts then go 18->17 on the same edge.
2. ch0: load 3, run=1, auto_reload=1, reload_val=7 -> per tick 3,2,1,0,7,6. warn=1 at 3,2,1. expire high exactly one cycle when 0 appears. finish=1 for the 4 cycles at 0.
3. ch1: auto_reload=0, load 2, run=1 -> 2,1,0. Count stays 0 for 5 more ticks despite run toggling. load 9 -> 9, then 8 on the next tick.
4. Pause: ch0 at 10, run=0 for 3 ticks -> holds 10. run=1 -> 9 on the next tick. ch1 keeps counting throughout.
5. Collision: load 12 asserted on a tick cycle -> count=12, not 11. load_val=0 -> finish=1, expire stays 0.
6. rst_n pulsed low between edges and released before the next edge -> no change. rst_n held low across an edge mid-count -> counts=18, expire=0, states IDLE, prescaler restarts (next tick 4 cycles after release).
